// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: issues req/gnt/rvalid fetches from a running PC,
// buffers returned words with their PCs and hands them to decode; EX jumps flush and redirect.
module instr_fetch_ctrl #(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_en_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        busy_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              active_q;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]       pc_mem_q   [FIFO_DEPTH];
    logic [31:0]       data_mem_q [FIFO_DEPTH];

    logic [31:0]       boot_aligned, jump_aligned;
    logic [CNT_W:0]    inflight;
    logic              issue, rsp, push, pop;
    logic              unused_addr_lsbs;

    assign boot_aligned     = {boot_addr_i[31:2], 2'b00};
    assign jump_aligned     = {jump_addr_i[31:2], 2'b00};
    assign unused_addr_lsbs = ^{boot_addr_i[1:0], jump_addr_i[1:0]};

    // Requests only when a buffer slot is guaranteed for every response in flight.
    assign inflight    = (CNT_W+1)'(outstanding_q) + (CNT_W+1)'(count_q);
    assign instr_req_o = active_q & fetch_en_i
                       & (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                       & (inflight < (CNT_W+1)'(FIFO_DEPTH));
    // Until the first edge out of reset the fetch PC is the boot address.
    assign instr_addr_o = active_q ? fetch_pc_q : boot_aligned;

    assign issue = instr_req_o & instr_gnt_i;
    assign rsp   = instr_rvalid_i & (outstanding_q != '0);
    assign push  = rsp & (discard_q == '0) & ~jump_flag_i;
    assign pop   = instr_valid_o & instr_ready_i & ~jump_flag_i;

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = data_mem_q[rd_ptr_q];
    assign instr_pc_o    = pc_mem_q[rd_ptr_q];
    assign busy_o        = (outstanding_q != '0) | (count_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;

        if (issue && !rsp) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!issue && rsp) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
        if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        if (!active_q) begin
            fetch_pc_d = boot_aligned;
            resp_pc_d  = boot_aligned;
        end
        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Every response still in flight after this edge belongs to the old stream.
        if (jump_flag_i) begin
            fetch_pc_d = jump_aligned;
            resp_pc_d  = jump_aligned;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q      <= 1'b0;
            fetch_pc_q    <= '0;
            resp_pc_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            active_q      <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Instruction buffer storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
            data_mem_q[wr_ptr_q] <= instr_rdata_i;
        end
    end

    // A response with nothing outstanding is a protocol error, except stale ones right after reset.
    always_ff @(posedge clk_i) begin
        if (active_q) begin
            assert (!(instr_rvalid_i && (outstanding_q == '0)))
                else $error("instr_fetch_ctrl: rvalid with no outstanding request");
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: memory model returns addr^K one cycle after grant,
// scoreboard checks popped PC/instruction order.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] boot_addr_i;
    logic        fetch_en_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        busy_o;

    int          tests = 0;
    int          fails = 0;
    int          pops  = 0;
    int          grants = 0;
    int          pops_b;
    logic        auto_rsp;
    logic [31:0] exp_pc;
    logic [31:0] pend [$];

    instr_fetch_ctrl #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .boot_addr_i    (boot_addr_i),
        .fetch_en_i     (fetch_en_i),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_ready_i  (instr_ready_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    // One clock: sample at negedge, advance, update the memory model just after the edge.
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        logic [31:0] tmp;
        @(negedge clk_i);
        g  = instr_req_o & instr_gnt_i;
        ga = instr_addr_o;
        if (instr_rvalid_i && pend.size() > 0) tmp = pend.pop_front();
        if (rst_ni && !jump_flag_i && instr_valid_o && instr_ready_i) begin
            check("pop_pc", instr_pc_o, exp_pc);
            check("pop_instr", instr_o, exp_pc ^ K);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (g) grants++;
        @(posedge clk_i);
        #1;
        if (g && rst_ni) pend.push_back(ga);
        if (auto_rsp) begin
            instr_rvalid_i = (pend.size() > 0);
            instr_rdata_i  = (pend.size() > 0) ? (pend[0] ^ K) : 32'h0;
        end
    endtask

    task automatic drain(input string tag);
        fetch_en_i    = 1'b0;
        instr_ready_i = 1'b1;
        instr_gnt_i   = 1'b1;
        auto_rsp      = 1'b1;
        for (int i = 0; i < 30 && busy_o; i++) tick();
        check(tag, 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        boot_addr_i    = 32'h0000_0100;
        fetch_en_i     = 1'b0;
        jump_flag_i    = 1'b0;
        jump_addr_i    = 32'h0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        instr_ready_i  = 1'b0;
        auto_rsp       = 1'b0;
        exp_pc         = 32'h0000_0100;
        #1;
        check("rst_req",   32'(instr_req_o),   32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_busy",  32'(busy_o),        32'd0);
        check("rst_instr", instr_o,            32'd0);
        check("rst_pc",    instr_pc_o,         32'd0);
        check("rst_addr",  instr_addr_o,       32'h0000_0100);
        repeat (2) tick();

        // Streaming fetch from boot address.
        rst_ni        = 1'b1;
        fetch_en_i    = 1'b1;
        instr_gnt_i   = 1'b1;
        instr_ready_i = 1'b1;
        auto_rsp      = 1'b1;
        tick();
        check("t1_first_req",  32'(instr_req_o), 32'd1);
        check("t1_first_addr", instr_addr_o,     32'h0000_0100);
        repeat (16) tick();
        check("t1_pop_count", 32'(pops >= 8), 32'd1);
        drain("t1_drain");

        // Decode stalled: only two grants, then request drops.
        instr_ready_i = 1'b0;
        fetch_en_i    = 1'b1;
        grants        = 0;
        repeat (6) tick();
        check("t2_grants", 32'(grants), 32'd2);
        check("t2_req",    32'(instr_req_o), 32'd0);
        check("t2_valid",  32'(instr_valid_o), 32'd1);
        pops_b = pops;
        drain("t2_drain");
        check("t2_pops", 32'(pops - pops_b), 32'd2);

        // One outstanding plus one buffered, then jump to 0x200.
        auto_rsp      = 1'b0;
        instr_ready_i = 1'b0;
        fetch_en_i    = 1'b1;
        instr_gnt_i   = 1'b1;
        tick();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = pend[0] ^ K;
        tick();
        instr_rvalid_i = 1'b0;
        check("t3_valid_pre", 32'(instr_valid_o), 32'd1);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0200;
        tick();
        jump_flag_i = 1'b0;
        instr_gnt_i = 1'b0;
        check("t3_valid_flush", 32'(instr_valid_o), 32'd0);
        check("t3_busy",        32'(busy_o),        32'd1);
        check("t3_addr",        instr_addr_o,       32'h0000_0200);
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = pend[0] ^ K;
        tick();
        instr_rvalid_i = 1'b0;
        check("t3_drop_valid", 32'(instr_valid_o), 32'd0);
        check("t3_drop_busy",  32'(busy_o),        32'd0);
        exp_pc        = 32'h0000_0200;
        instr_gnt_i   = 1'b1;
        instr_ready_i = 1'b1;
        auto_rsp      = 1'b1;
        pops_b        = pops;
        repeat (6) tick();
        check("t3_pops", 32'(pops - pops_b >= 2), 32'd1);
        drain("t3_drain");

        // Jump coinciding with grant and response; unaligned target.
        auto_rsp      = 1'b0;
        instr_ready_i = 1'b0;
        fetch_en_i    = 1'b1;
        instr_gnt_i   = 1'b1;
        tick();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = pend[0] ^ K;
        jump_flag_i    = 1'b1;
        jump_addr_i    = 32'h0000_0203;
        tick();
        check("t4_jump_grant", 32'(grants > 0 && pend.size() == 1), 32'd1);
        jump_flag_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_gnt_i    = 1'b0;
        check("t4_valid", 32'(instr_valid_o), 32'd0);
        check("t4_busy",  32'(busy_o),        32'd1);
        check("t4_addr",  instr_addr_o,       32'h0000_0200);
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = pend[0] ^ K;
        tick();
        instr_rvalid_i = 1'b0;
        check("t4_drop_valid", 32'(instr_valid_o), 32'd0);
        check("t4_drop_busy",  32'(busy_o),        32'd0);
        exp_pc        = 32'h0000_0200;
        instr_gnt_i   = 1'b1;
        instr_ready_i = 1'b1;
        auto_rsp      = 1'b1;
        pops_b        = pops;
        repeat (6) tick();
        check("t4_pops", 32'(pops - pops_b >= 2), 32'd1);
        drain("t4_drain");

        // Address wrap past 0xFFFFFFFC.
        fetch_en_i  = 1'b0;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'hFFFF_FFF8;
        tick();
        jump_flag_i = 1'b0;
        check("t5_addr", instr_addr_o, 32'hFFFF_FFF8);
        exp_pc     = 32'hFFFF_FFF8;
        fetch_en_i = 1'b1;
        pops_b     = pops;
        repeat (8) tick();
        check("t5_pops", 32'(pops - pops_b >= 4), 32'd1);
        drain("t5_drain");

        // Reset with one request outstanding; stale response afterwards is ignored.
        auto_rsp      = 1'b0;
        instr_ready_i = 1'b0;
        fetch_en_i    = 1'b1;
        instr_gnt_i   = 1'b1;
        tick();
        check("t6_busy_pre", 32'(busy_o), 32'd1);
        instr_gnt_i = 1'b0;
        fetch_en_i  = 1'b0;
        rst_ni      = 1'b0;
        boot_addr_i = 32'h0000_0302;
        pend.delete();
        #1;
        check("t6_rst_busy", 32'(busy_o),      32'd0);
        check("t6_rst_req",  32'(instr_req_o), 32'd0);
        repeat (2) tick();
        check("t6_rst_busy2", 32'(busy_o), 32'd0);
        rst_ni         = 1'b1;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hDEAD_BEEF;
        tick();
        instr_rvalid_i = 1'b0;
        check("t6_stale_valid", 32'(instr_valid_o), 32'd0);
        check("t6_stale_busy",  32'(busy_o),        32'd0);
        check("t6_boot_addr",   instr_addr_o,       32'h0000_0300);
        exp_pc        = 32'h0000_0300;
        fetch_en_i    = 1'b1;
        instr_gnt_i   = 1'b1;
        instr_ready_i = 1'b1;
        auto_rsp      = 1'b1;
        pops_b        = pops;
        repeat (6) tick();
        check("t6_pops", 32'(pops - pops_b >= 2), 32'd1);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
